eot_gen_cfg: RTL and testbench

- Runtime-configurable successor to the fixed-size end-of-transaction tagger.
- Passes a data stream through a registered output stage and tags each beat with a 3-level EOT: row end, window end, batch end.
- Window width, height and windows-per-batch are loaded per batch over a config handshake.
- Sits between the image/window fetch and the feature evaluation pipeline of the cascade classifier.

---
 rtl/eot_gen_cfg_if.sv | 76 +++++++
 rtl/eot_gen_cfg.sv | 238 +++++++++++++++++++++++
 tb/tb_eot_gen_cfg.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eot_gen_cfg_if.sv
// eot_gen_cfg_if: config, input-stream and output-stream signals of the
// end-of-transaction tagger.
// The master side drives config and input beats and consumes output beats.
// The slave side is the tagger itself.
// Optional: define EOT_GEN_CHECK_EN to carry the upstream batch-end marker
// din_last alongside each input beat.
interface eot_gen_cfg_if #(
    parameter int W_DATA      = 8,
    parameter int MAX_WIDTH   = 24,
    parameter int MAX_HEIGHT  = 24,
    parameter int MAX_WINDOWS = 1024
);
    localparam int W_X = $clog2(MAX_WIDTH);
    localparam int W_Y = $clog2(MAX_HEIGHT);
    localparam int W_N = $clog2(MAX_WINDOWS);

    // Config handshake
    logic              cfg_valid;
    logic              cfg_ready;
    logic [W_X-1:0]    cfg_width_m1;
    logic [W_Y-1:0]    cfg_height_m1;
    logic [W_N-1:0]    cfg_nwin_m1;

    // Input stream
    logic              din_valid;
    logic              din_ready;
    logic [W_DATA-1:0] din_data;
`ifdef EOT_GEN_CHECK_EN
    logic              din_last;
`endif

    // Output stream
    logic              dout_valid;
    logic              dout_ready;
    logic [W_DATA-1:0] dout_data;
    logic [2:0]        dout_eot;

`ifdef EOT_GEN_CHECK_EN
    modport master (
        output cfg_valid, cfg_width_m1, cfg_height_m1, cfg_nwin_m1,
        input  cfg_ready,
        output din_valid, din_data, din_last,
        input  din_ready,
        input  dout_valid, dout_data, dout_eot,
        output dout_ready
    );

    modport slave (
        input  cfg_valid, cfg_width_m1, cfg_height_m1, cfg_nwin_m1,
        output cfg_ready,
        input  din_valid, din_data, din_last,
        output din_ready,
        output dout_valid, dout_data, dout_eot,
        input  dout_ready
    );
`else
    modport master (
        output cfg_valid, cfg_width_m1, cfg_height_m1, cfg_nwin_m1,
        input  cfg_ready,
        output din_valid, din_data,
        input  din_ready,
        input  dout_valid, dout_data, dout_eot,
        output dout_ready
    );

    modport slave (
        input  cfg_valid, cfg_width_m1, cfg_height_m1, cfg_nwin_m1,
        output cfg_ready,
        input  din_valid, din_data,
        output din_ready,
        output dout_valid, dout_data, dout_eot,
        input  dout_ready
    );
`endif

endinterface

// File: rtl/eot_gen_cfg.sv
// eot_gen_cfg: runtime-configurable end-of-transaction tagger.
// Passes a beat stream through a one-entry registered output stage.
// Each beat is tagged with a 3-level EOT: [0] row end, [1] window end,
// [2] batch end.
// Window width/height and windows-per-batch are loaded once per batch over
// the config handshake while idle.
// Optional: define EOT_GEN_CHECK_EN to add a din_last input (on the
// interface) and a sticky err output that flags din_last != batch end.
module eot_gen_cfg #(
    parameter int W_DATA      = 8,
    parameter int MAX_WIDTH   = 24,
    parameter int MAX_HEIGHT  = 24,
    parameter int MAX_WINDOWS = 1024
) (
    input  logic         clk,
    input  logic         rst,
    eot_gen_cfg_if.slave bus,
    output logic         busy
`ifdef EOT_GEN_CHECK_EN
    ,
    output logic         err
`endif
);

    localparam int W_X = $clog2(MAX_WIDTH);
    localparam int W_Y = $clog2(MAX_HEIGHT);
    localparam int W_N = $clog2(MAX_WINDOWS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;

    // Batch geometry latched at the config handshake
    logic [W_X-1:0]    width_m1_q,  width_m1_d;
    logic [W_Y-1:0]    height_m1_q, height_m1_d;
    logic [W_N-1:0]    nwin_m1_q,   nwin_m1_d;

    // Position of the next accepted beat inside the batch
    logic [W_X-1:0]    x_q, x_d;
    logic [W_Y-1:0]    y_q, y_d;
    logic [W_N-1:0]    n_q, n_d;

    // One-entry output register
    logic              dout_valid_q, dout_valid_d;
    logic [W_DATA-1:0] dout_data_q,  dout_data_d;
    logic [2:0]        dout_eot_q,   dout_eot_d;

    logic              cfg_ready;
    logic              din_ready;
    logic              cfg_fire;
    logic              din_fire;
    logic              dout_fire;
    logic              e0, e1, e2;

    assign cfg_fire  = bus.cfg_valid & cfg_ready;
    assign din_fire  = bus.din_valid & din_ready;
    assign dout_fire = dout_valid_q & bus.dout_ready;

    // Tags come from the pre-increment counters; each level is gated by the
    // level below so the implication e2 -> e1 -> e0 holds by construction.
    assign e0 = (x_q == width_m1_q);
    assign e1 = e0 & (y_q == height_m1_q);
    assign e2 = e1 & (n_q == nwin_m1_q);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values of its peers regardless of block order.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: config starts a batch, the batch-end beat starts the
    // drain, and the drain ends when that beat leaves the output register.
    always_comb begin
        // NOTE: the default assignment first keeps every path assigned, so no
        // latch is inferred when a branch leaves the state unchanged.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cfg_fire)        state_d = RUN;
            RUN:     if (din_fire && e2)  state_d = DRAIN;
            DRAIN:   if (dout_fire)       state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // FSM outputs: handshake readies and the busy status
    always_comb begin
        cfg_ready = 1'b0;
        din_ready = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
            end
            RUN: begin
                // Accept whenever the output slot is empty or emptying now,
                // which gives one beat per cycle with no bubbles.
                din_ready = !dout_valid_q || bus.dout_ready;
                busy      = 1'b1;
            end
            DRAIN: begin
                busy      = 1'b1;
            end
            default: begin
                cfg_ready = 1'b0;
            end
        endcase
    end

    assign bus.cfg_ready = cfg_ready;
    assign bus.din_ready = din_ready;

    // Config next-state: capture geometry only on the config handshake
    always_comb begin
        width_m1_d  = width_m1_q;
        height_m1_d = height_m1_q;
        nwin_m1_d   = nwin_m1_q;
        if (cfg_fire) begin
            width_m1_d  = bus.cfg_width_m1;
            height_m1_d = bus.cfg_height_m1;
            nwin_m1_d   = bus.cfg_nwin_m1;
        end
    end

    // Config registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            width_m1_q  <= '0;
            height_m1_q <= '0;
            nwin_m1_q   <= '0;
        end else begin
            width_m1_q  <= width_m1_d;
            height_m1_q <= height_m1_d;
            nwin_m1_q   <= nwin_m1_d;
        end
    end

    // Counter next-state: cleared per batch, nested wrap on each accepted beat
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        n_d = n_q;
        if (cfg_fire) begin
            x_d = '0;
            y_d = '0;
            n_d = '0;
        end else if (din_fire) begin
            x_d = e0 ? '0 : x_q + W_X'(1);
            if (e0) begin
                y_d = e1 ? '0 : y_q + W_Y'(1);
            end
            if (e1) begin
                n_d = e2 ? '0 : n_q + W_N'(1);
            end
        end
    end

    // Position counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
            n_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            n_q <= n_d;
        end
    end

    // Output register next-state: a new beat overwrites the slot (also when
    // the old beat drains in the same cycle); otherwise data and tags hold
    // and only the valid flag drops once the beat is taken.
    always_comb begin
        dout_valid_d = dout_valid_q;
        dout_data_d  = dout_data_q;
        dout_eot_d   = dout_eot_q;
        if (din_fire) begin
            dout_valid_d = 1'b1;
            dout_data_d  = bus.din_data;
            dout_eot_d   = {e2, e1, e0};
        end else if (dout_fire) begin
            dout_valid_d = 1'b0;
        end
    end

    // Output register; reset clears it immediately, discarding any held beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_valid_q <= 1'b0;
            dout_data_q  <= '0;
            dout_eot_q   <= '0;
        end else begin
            dout_valid_q <= dout_valid_d;
            dout_data_q  <= dout_data_d;
            dout_eot_q   <= dout_eot_d;
        end
    end

    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_data  = dout_data_q;
    assign bus.dout_eot   = dout_eot_q;

`ifdef EOT_GEN_CHECK_EN
    logic err_q, err_d;

    // Check next-state: a new batch clears the flag, any beat whose upstream
    // marker disagrees with the computed batch end sets it until then.
    always_comb begin
        err_d = err_q;
        if (cfg_fire) begin
            err_d = 1'b0;
        end else if (din_fire && (bus.din_last != e2)) begin
            err_d = 1'b1;
        end
    end

    // Sticky mismatch flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_eot_gen_cfg.sv
// tb_eot_gen_cfg: directed bench for eot_gen_cfg.
// A queue-based model derives each beat's tags from its index in the batch
// and is compared with the DUT on every falling edge; literal expectations
// pin the model on the key cases.
// Define EOT_GEN_CHECK_EN to also exercise the din_last / err check.
module tb_eot_gen_cfg;

    logic clk;
    logic rst;
    logic busy;
`ifdef EOT_GEN_CHECK_EN
    logic err;
`endif

    eot_gen_cfg_if bus ();

    eot_gen_cfg dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
`ifdef EOT_GEN_CHECK_EN
        ,
        .err  (err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_RUN, M_DRAIN} m_state_e;
    typedef struct packed {
        logic [7:0] data;
        logic [2:0] eot;
    } beat_t;

    m_state_e m_state;
    beat_t    mq[$];       // beats accepted but not yet delivered
    beat_t    out_log[$];  // DUT beats observed at each output handshake
    int       m_w, m_h, m_n, m_k;
    bit       m_cfg_fire, m_in_fire, m_out_fire;
    bit       m_err;
    bit       cfg_ok, in_ok, out_ok;
    int       wh, wt;
    beat_t    nb, ob;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state    = M_IDLE;
            mq.delete();
            m_k        = 0;
            m_w        = 1;
            m_h        = 1;
            m_n        = 1;
            m_cfg_fire = 0;
            m_in_fire  = 0;
            m_out_fire = 0;
            m_err      = 0;
        end else begin
            cfg_ok = (m_state == M_IDLE) && bus.cfg_valid;
            out_ok = (mq.size() > 0) && bus.dout_ready;
            in_ok  = (m_state == M_RUN) && bus.din_valid && ((mq.size() == 0) || bus.dout_ready);
            m_cfg_fire = cfg_ok;
            m_in_fire  = in_ok;
            m_out_fire = out_ok;
            if (out_ok) begin
                ob = {bus.dout_data, bus.dout_eot};
                out_log.push_back(ob);
                void'(mq.pop_front());
                if (m_state == M_DRAIN) m_state = M_IDLE;
            end
            if (in_ok) begin
                wh = m_w * m_h;
                wt = wh * m_n;
                nb.data   = bus.din_data;
                nb.eot[0] = ((m_k % m_w) == m_w - 1);
                nb.eot[1] = ((m_k % wh) == wh - 1);
                nb.eot[2] = (m_k == wt - 1);
`ifdef EOT_GEN_CHECK_EN
                if (bus.din_last != nb.eot[2]) m_err = 1;
`endif
                mq.push_back(nb);
                m_k++;
                if (nb.eot[2]) m_state = M_DRAIN;
            end
            if (cfg_ok) begin
                m_w     = int'(bus.cfg_width_m1) + 1;
                m_h     = int'(bus.cfg_height_m1) + 1;
                m_n     = int'(bus.cfg_nwin_m1) + 1;
                m_k     = 0;
                m_err   = 0;
                m_state = M_RUN;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            check("cfg_ready", bus.cfg_ready, m_state == M_IDLE);
            check("busy", busy, m_state != M_IDLE);
            check("din_ready", bus.din_ready,
                  (m_state == M_RUN) && ((mq.size() == 0) || bus.dout_ready));
            check("dout_valid", bus.dout_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                check("dout_data", bus.dout_data, mq[0].data);
                check("dout_eot", bus.dout_eot, mq[0].eot);
            end
`ifdef EOT_GEN_CHECK_EN
            check("err", err, m_err);
`endif
        end
    end

    // ---------------- stimulus ----------------
    int rdy_mode = 0;  // 0: always ready, 1: toggle every cycle

    initial begin
        bus.dout_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) bus.dout_ready = ~bus.dout_ready;
            else               bus.dout_ready = 1'b1;
        end
    end

    task automatic do_cfg(input int w_m1, input int h_m1, input int n_m1);
        bit got = 0;
        bus.cfg_valid     = 1'b1;
        bus.cfg_width_m1  = 5'(w_m1);
        bus.cfg_height_m1 = 5'(h_m1);
        bus.cfg_nwin_m1   = 10'(n_m1);
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk);
            #1;
            if (m_cfg_fire) got = 1;
        end
        bus.cfg_valid = 1'b0;
        check("cfg_accepted", got, 1);
    endtask

    task automatic send_beats(input int count, input logic [7:0] d0, input bit rnd,
                              input int last_idx, output int cycles);
        int idx = 0;
        cycles = 0;
        while (idx < count && cycles < 5000) begin
            bus.din_valid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            bus.din_data  = d0 + 8'(idx);
`ifdef EOT_GEN_CHECK_EN
            bus.din_last  = (idx == last_idx);
`endif
            @(posedge clk);
            #1;
            cycles++;
            if (m_in_fire) idx++;
        end
        bus.din_valid = 1'b0;
`ifdef EOT_GEN_CHECK_EN
        bus.din_last  = 1'b0;
`endif
        check("beats_sent", idx, count);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (m_state == M_IDLE && mq.size() == 0) ok = 1;
        end
        check("idle_reached", ok, 1);
    endtask

    int cyc;
    int c0, c1, c2;
    int waits;
    bit got4;

    initial begin
        rst               = 1'b1;
        bus.cfg_valid     = 1'b0;
        bus.cfg_width_m1  = '0;
        bus.cfg_height_m1 = '0;
        bus.cfg_nwin_m1   = '0;
        bus.din_valid     = 1'b0;
        bus.din_data      = '0;
`ifdef EOT_GEN_CHECK_EN
        bus.din_last      = 1'b0;
`endif

        // Reset state
        #12;
        check("rst_cfg_ready", bus.cfg_ready, 1);
        check("rst_din_ready", bus.din_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_dout_valid", bus.dout_valid, 0);
        check("rst_dout_data", bus.dout_data, 0);
        check("rst_dout_eot", bus.dout_eot, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1) 24x24, two windows, full throughput
        out_log.delete();
        rdy_mode = 0;
        do_cfg(23, 23, 1);
        send_beats(1152, 8'h00, 1'b0, 1151, cyc);
        check("t1_cycles", cyc, 1152);
        check("t1_drain_busy", busy, 1);
        check("t1_drain_eot", bus.dout_eot, 3'b111);
        @(posedge clk);
        #1;
        check("t1_idle_busy", busy, 0);
        check("t1_idle_cfg_ready", bus.cfg_ready, 1);
        c0 = 0; c1 = 0; c2 = 0;
        foreach (out_log[i]) begin
            c0 += int'(out_log[i].eot[0]);
            c1 += int'(out_log[i].eot[1]);
            c2 += int'(out_log[i].eot[2]);
        end
        check("t1_beats", out_log.size(), 1152);
        check("t1_eot0_count", c0, 48);
        check("t1_eot1_count", c1, 2);
        check("t1_eot2_count", c2, 1);
        check("t1_beat23_eot", out_log[23].eot, 3'b001);
        check("t1_beat576_eot", out_log[575].eot, 3'b011);
        check("t1_beat1152_eot", out_log[1151].eot, 3'b111);
        check("t1_beat1152_data", out_log[1151].data, 8'h7f);

        // 2) single-beat batch
        out_log.delete();
        do_cfg(0, 0, 0);
        send_beats(1, 8'hA5, 1'b0, 0, cyc);
        check("t2_dout_valid", bus.dout_valid, 1);
        check("t2_dout_data", bus.dout_data, 8'hA5);
        check("t2_dout_eot", bus.dout_eot, 3'b111);
        @(posedge clk);
        #1;
        check("t2_idle_cfg_ready", bus.cfg_ready, 1);
        check("t2_idle_busy", busy, 0);
        check("t2_idle_dout_valid", bus.dout_valid, 0);

        // 3) 3x2, one window, toggling ready and random valid
        out_log.delete();
        rdy_mode = 1;
        do_cfg(2, 1, 0);
        send_beats(6, 8'h30, 1'b1, 5, cyc);
        wait_idle();
        rdy_mode = 0;
        check("t3_beats", out_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check("t3_data", out_log[i].data, 8'h30 + 8'(i));
        end
        check("t3_eot0", out_log[0].eot, 3'b000);
        check("t3_eot2", out_log[2].eot, 3'b001);
        check("t3_eot3", out_log[3].eot, 3'b000);
        check("t3_eot5", out_log[5].eot, 3'b111);

        // 4) config offered during RUN is held off until IDLE
        out_log.delete();
        do_cfg(2, 0, 0);
        bus.cfg_valid     = 1'b1;
        bus.cfg_width_m1  = 5'd1;
        bus.cfg_height_m1 = 5'd0;
        bus.cfg_nwin_m1   = 10'd0;
        send_beats(3, 8'h50, 1'b0, 2, cyc);
        waits = 0;
        got4  = 0;
        while (!got4 && waits < 20) begin
            @(posedge clk);
            #1;
            waits++;
            if (m_cfg_fire) got4 = 1;
        end
        bus.cfg_valid = 1'b0;
        check("t4_cfg_accepted", got4, 1);
        check("t4_cfg_wait", waits, 2);
        send_beats(2, 8'h58, 1'b0, 1, cyc);
        wait_idle();
        check("t4_beats", out_log.size(), 5);
        check("t4_eot1", out_log[1].eot, 3'b000);
        check("t4_eot2", out_log[2].eot, 3'b111);
        check("t4_eot3", out_log[3].eot, 3'b000);
        check("t4_eot4", out_log[4].eot, 3'b111);

        // 5) asynchronous reset mid-window, then restart
        do_cfg(3, 3, 0);
        send_beats(10, 8'h10, 1'b0, 15, cyc);
        #3;
        rst = 1'b1;
        #1;
        check("t5_rst_dout_valid", bus.dout_valid, 0);
        check("t5_rst_dout_data", bus.dout_data, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_cfg_ready", bus.cfg_ready, 1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_log.delete();
        do_cfg(3, 3, 0);
        send_beats(16, 8'h40, 1'b0, 15, cyc);
        wait_idle();
        check("t5_beats", out_log.size(), 16);
        check("t5_beat3_eot", out_log[2].eot, 3'b000);
        check("t5_beat4_eot", out_log[3].eot, 3'b001);
        check("t5_beat4_data", out_log[3].data, 8'h43);
        check("t5_beat16_eot", out_log[15].eot, 3'b111);

`ifdef EOT_GEN_CHECK_EN
        // 6) batch-end marker arrives one beat early
        do_cfg(1, 1, 0);
        send_beats(4, 8'h60, 1'b0, 2, cyc);
        wait_idle();
        check("t6_err_set", err, 1);
        repeat (3) @(posedge clk);
        #1;
        check("t6_err_sticky", err, 1);
        do_cfg(0, 0, 0);
        check("t6_err_cleared", err, 0);
        send_beats(1, 8'h70, 1'b0, 0, cyc);
        wait_idle();
        check("t6_err_clean", err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
